// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM state encoding and the per-cycle stall/flush bundle.
// Pure declarations, no logic.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      CTRL_RUN      = 2'd0,
      CTRL_MDU_WAIT = 2'd1,
      CTRL_LSU_WAIT = 2'd2,
      CTRL_TRAP     = 2'd3
   } ctrl_state_e;

   typedef struct packed {
      logic stall_if;
      logic stall_id;
      logic stall_ex;
      logic stall_mem;
      logic flush_id;
      logic flush_ex;
      logic flush_mem;
      logic mdu_start;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs from the pipeline and stall/flush/forward controls back to it.
// master = core datapath side, slave = pipe_ctrl.
interface pipe_ctrl_if #(
   parameter int RF_AW = 5,
   parameter int CNT_W = 32
);
   logic [RF_AW-1:0] id_rs1_addr;
   logic [RF_AW-1:0] id_rs2_addr;
   logic             id_rs1_rd;
   logic             id_rs2_rd;
   logic             id2ex_reg_wen;
   logic [RF_AW-1:0] id2ex_reg_waddr;
   logic             id2ex_mem_rd;
   logic             ex2mem_reg_wen;
   logic [RF_AW-1:0] ex2mem_reg_waddr;
   logic             ex2mem_ill_instr;
   logic             take_branch;
   logic             ex_mdu_instr;
   logic             mdu_done;
   logic             lsu_busy;
   logic             trap_ack;

   logic             op1_fwd_mem;
   logic             op1_fwd_wb;
   logic             op2_fwd_mem;
   logic             op2_fwd_wb;
   logic             stall_if;
   logic             stall_id;
   logic             stall_ex;
   logic             stall_mem;
   logic             flush_id;
   logic             flush_ex;
   logic             flush_mem;
   logic             mdu_start;
   logic             trap_req;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_rs1_addr, id_rs2_addr, id_rs1_rd, id_rs2_rd,
             id2ex_reg_wen, id2ex_reg_waddr, id2ex_mem_rd,
             ex2mem_reg_wen, ex2mem_reg_waddr, ex2mem_ill_instr,
             take_branch, ex_mdu_instr, mdu_done, lsu_busy, trap_ack,
      input  op1_fwd_mem, op1_fwd_wb, op2_fwd_mem, op2_fwd_wb,
             stall_if, stall_id, stall_ex, stall_mem,
             flush_id, flush_ex, flush_mem, mdu_start, trap_req,
             stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs1_addr, id_rs2_addr, id_rs1_rd, id_rs2_rd,
             id2ex_reg_wen, id2ex_reg_waddr, id2ex_mem_rd,
             ex2mem_reg_wen, ex2mem_reg_waddr, ex2mem_ill_instr,
             take_branch, ex_mdu_instr, mdu_done, lsu_busy, trap_ack,
      output op1_fwd_mem, op1_fwd_wb, op2_fwd_mem, op2_fwd_wb,
             stall_if, stall_id, stall_ex, stall_mem,
             flush_id, flush_ex, flush_mem, mdu_start, trap_req,
             stall_cnt, flush_cnt
   );

endinterface

// File: rtl/pipe_ctrl_hazard_cmp.sv
// Per-operand hazard comparator for the instruction in ID; purely combinational.
// EX-stage producer wins over MEM-stage producer; x0 never matches.
module pipe_ctrl_hazard_cmp #(
   parameter int RF_AW = 5
) (
   input  logic [RF_AW-1:0] rs_addr,
   input  logic             rs_rd,
   input  logic             ex_wen,
   input  logic [RF_AW-1:0] ex_waddr,
   input  logic             ex_mem_rd,
   input  logic             mem_wen,
   input  logic [RF_AW-1:0] mem_waddr,
   output logic             fwd_mem,
   output logic             fwd_wb,
   output logic             load_use
);
   logic rs_live;
   logic ex_hit;

   assign rs_live  = rs_rd && (rs_addr != '0);
   assign ex_hit   = rs_live && ex_wen && (ex_waddr == rs_addr);
   // A load in EX has no data yet: interlock instead of forwarding from MEM.
   assign fwd_mem  = ex_hit && !ex_mem_rd;
   assign load_use = ex_hit && ex_mem_rd;
   assign fwd_wb   = !fwd_mem && rs_live && mem_wen && (mem_waddr == rs_addr);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: forward selects, stall/flush per stage, MDU/LSU/trap sequencing, perf counters.
// Stall/flush/forward are combinational on the current cycle; trap_req and counters are registered.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int RF_AW = 5,
   parameter int CNT_W = 32
) (
   input logic        clk,
   input logic        rst,
   pipe_ctrl_if.slave pif
);
   logic             op1_fwd_mem, op1_fwd_wb, op1_lu;
   logic             op2_fwd_mem, op2_fwd_wb, op2_lu;
   logic             load_use;
   logic             stall_any;
   ctrl_state_e      state_q;
   logic             trap_q;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;
   ctrl_t            ctrl;

   pipe_ctrl_hazard_cmp #(.RF_AW(RF_AW)) u_rs1 (
      .rs_addr   (pif.id_rs1_addr),
      .rs_rd     (pif.id_rs1_rd),
      .ex_wen    (pif.id2ex_reg_wen),
      .ex_waddr  (pif.id2ex_reg_waddr),
      .ex_mem_rd (pif.id2ex_mem_rd),
      .mem_wen   (pif.ex2mem_reg_wen),
      .mem_waddr (pif.ex2mem_reg_waddr),
      .fwd_mem   (op1_fwd_mem),
      .fwd_wb    (op1_fwd_wb),
      .load_use  (op1_lu)
   );

   pipe_ctrl_hazard_cmp #(.RF_AW(RF_AW)) u_rs2 (
      .rs_addr   (pif.id_rs2_addr),
      .rs_rd     (pif.id_rs2_rd),
      .ex_wen    (pif.id2ex_reg_wen),
      .ex_waddr  (pif.id2ex_reg_waddr),
      .ex_mem_rd (pif.id2ex_mem_rd),
      .mem_wen   (pif.ex2mem_reg_wen),
      .mem_waddr (pif.ex2mem_reg_waddr),
      .fwd_mem   (op2_fwd_mem),
      .fwd_wb    (op2_fwd_wb),
      .load_use  (op2_lu)
   );

   assign load_use = op1_lu || op2_lu;

   always_comb begin
      ctrl = CTRL_IDLE;
      if (rst) begin
         ctrl.flush_id  = 1'b1;
         ctrl.flush_ex  = 1'b1;
         ctrl.flush_mem = 1'b1;
      end else begin
         case (state_q)
            CTRL_MDU_WAIT: begin
               // A slow LSU holds MEM; the bubble behind the MDU op must not overwrite it.
               ctrl.stall_mem = pif.lsu_busy;
               if (!pif.mdu_done) begin
                  ctrl.stall_if  = 1'b1;
                  ctrl.stall_id  = 1'b1;
                  ctrl.stall_ex  = 1'b1;
                  ctrl.flush_mem = !pif.lsu_busy;
               end
            end
            CTRL_TRAP: ctrl.stall_if = !pif.trap_ack;
            default: begin
               if (pif.ex2mem_ill_instr) begin
                  ctrl.flush_id  = 1'b1;
                  ctrl.flush_ex  = 1'b1;
                  ctrl.flush_mem = 1'b1;
               end else if (pif.lsu_busy) begin
                  ctrl.stall_if  = 1'b1;
                  ctrl.stall_id  = 1'b1;
                  ctrl.stall_ex  = 1'b1;
                  ctrl.stall_mem = 1'b1;
               end else if (pif.ex_mdu_instr) begin
                  ctrl.mdu_start = 1'b1;
                  ctrl.stall_if  = 1'b1;
                  ctrl.stall_id  = 1'b1;
                  ctrl.stall_ex  = 1'b1;
                  ctrl.flush_mem = 1'b1;
               end else if (pif.take_branch) begin
                  ctrl.flush_id = 1'b1;
                  ctrl.flush_ex = 1'b1;
               end else if (load_use) begin
                  ctrl.stall_if = 1'b1;
                  ctrl.stall_id = 1'b1;
                  ctrl.flush_ex = 1'b1;
               end
            end
         endcase
      end
   end

   assign stall_any = ctrl.stall_if || ctrl.stall_id || ctrl.stall_ex || ctrl.stall_mem;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= CTRL_RUN;
         trap_q      <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         case (state_q)
            CTRL_MDU_WAIT: if (pif.mdu_done) state_q <= CTRL_RUN;
            CTRL_TRAP: begin
               if (pif.trap_ack) begin
                  state_q <= CTRL_RUN;
                  trap_q  <= 1'b0;
               end
            end
            default: begin
               if (pif.ex2mem_ill_instr) begin
                  state_q <= CTRL_TRAP;
                  trap_q  <= 1'b1;
               end else if (pif.lsu_busy) begin
                  state_q <= CTRL_LSU_WAIT;
               end else if (pif.ex_mdu_instr) begin
                  state_q <= CTRL_MDU_WAIT;
               end else begin
                  state_q <= CTRL_RUN;
               end
            end
         endcase
         if (stall_any && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (ctrl.flush_id && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign pif.op1_fwd_mem = op1_fwd_mem && !rst;
   assign pif.op1_fwd_wb  = op1_fwd_wb && !rst;
   assign pif.op2_fwd_mem = op2_fwd_mem && !rst;
   assign pif.op2_fwd_wb  = op2_fwd_wb && !rst;
   assign pif.stall_if    = ctrl.stall_if;
   assign pif.stall_id    = ctrl.stall_id;
   assign pif.stall_ex    = ctrl.stall_ex;
   assign pif.stall_mem   = ctrl.stall_mem;
   assign pif.flush_id    = ctrl.flush_id;
   assign pif.flush_ex    = ctrl.flush_ex;
   assign pif.flush_mem   = ctrl.flush_mem;
   assign pif.mdu_start   = ctrl.mdu_start;
   assign pif.trap_req    = trap_q && !rst;
   assign pif.stall_cnt   = stall_cnt_q;
   assign pif.flush_cnt   = flush_cnt_q;

   a_no_branch_with_mdu: assert property (@(posedge clk) disable iff (rst)
      !(pif.take_branch && pif.ex_mdu_instr));

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl: the driver queues the hand-derived expected controls per cycle,
// a monitor pops and compares every cycle. Counters are 4 bits wide so saturation is reachable.
module tb_pipe_ctrl;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   pipe_ctrl_if #(.RF_AW(5), .CNT_W(4)) pif ();
   pipe_ctrl #(.RF_AW(5), .CNT_W(4)) dut (.clk(clk), .rst(rst), .pif(pif.slave));

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [1:0] rd;
      logic       ex_wen;
      logic [4:0] ex_wa;
      logic       ex_ld;
      logic       mem_wen;
      logic [4:0] mem_wa;
      logic [6:0] ctl;
   } in_t;

   // ctl = {rst, ill, lsu_busy, ex_mdu, mdu_done, take_branch, trap_ack}
   localparam logic [6:0] C_NONE = 7'h00, C_RST = 7'h40, C_ILL = 7'h20, C_LSU = 7'h10,
                          C_MDU = 7'h08, C_DONE = 7'h04, C_BR = 7'h02, C_ACK = 7'h01;

   // exp = {op1m,op1w,op2m,op2w}_{sif,sid,sex,smem}_{fid,fex,fmem}_{mdu_start}_{trap_req}
   localparam logic [12:0] E_NONE  = 13'b0000_0000_000_0_0;
   localparam logic [12:0] E_RST   = 13'b0000_0000_111_0_0;
   localparam logic [12:0] E_LU    = 13'b0000_1100_010_0_0;
   localparam logic [12:0] E_BR    = 13'b0000_0000_110_0_0;
   localparam logic [12:0] E_MDU0  = 13'b0000_1110_001_1_0;
   localparam logic [12:0] E_MDUW  = 13'b0000_1110_001_0_0;
   localparam logic [12:0] E_STALL = 13'b0000_1111_000_0_0;
   localparam logic [12:0] E_TRAPW = 13'b0000_1000_000_0_1;
   localparam logic [12:0] E_TRAPA = 13'b0000_0000_000_0_1;

   logic [20:0] exp_q[$];
   string       name_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [3:0]  exp_sc = '0;
   logic [3:0]  exp_fc = '0;
   logic [20:0] mon_exp, mon_act;
   string       mon_name;

   function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [1:0] rd,
                              input logic ex_wen, input logic [4:0] ex_wa, input logic ex_ld,
                              input logic mem_wen, input logic [4:0] mem_wa, input logic [6:0] ctl);
      mk = {rs1, rs2, rd, ex_wen, ex_wa, ex_ld, mem_wen, mem_wa, ctl};
   endfunction

   task automatic apply(input in_t v);
      rst                  = v.ctl[6];
      pif.id_rs1_addr      = v.rs1;
      pif.id_rs2_addr      = v.rs2;
      pif.id_rs1_rd        = v.rd[1];
      pif.id_rs2_rd        = v.rd[0];
      pif.id2ex_reg_wen    = v.ex_wen;
      pif.id2ex_reg_waddr  = v.ex_wa;
      pif.id2ex_mem_rd     = v.ex_ld;
      pif.ex2mem_reg_wen   = v.mem_wen;
      pif.ex2mem_reg_waddr = v.mem_wa;
      pif.ex2mem_ill_instr = v.ctl[5];
      pif.lsu_busy         = v.ctl[4];
      pif.ex_mdu_instr     = v.ctl[3];
      pif.mdu_done         = v.ctl[2];
      pif.take_branch      = v.ctl[1];
      pif.trap_ack         = v.ctl[0];
   endtask

   // Counters seen in a cycle reflect the expected stall/flush activity of earlier cycles.
   task automatic step(input string nm, input in_t v, input logic [12:0] e);
      @(posedge clk);
      #1;
      apply(v);
      exp_q.push_back({e, exp_sc, exp_fc});
      name_q.push_back(nm);
      if (v.ctl[6]) begin
         exp_sc = '0;
         exp_fc = '0;
      end else begin
         if ((|e[8:5]) && exp_sc != 4'hF) exp_sc = exp_sc + 4'd1;
         if (e[4] && exp_fc != 4'hF) exp_fc = exp_fc + 4'd1;
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         mon_exp  = exp_q.pop_front();
         mon_name = name_q.pop_front();
         mon_act  = {pif.op1_fwd_mem, pif.op1_fwd_wb, pif.op2_fwd_mem, pif.op2_fwd_wb,
                     pif.stall_if, pif.stall_id, pif.stall_ex, pif.stall_mem,
                     pif.flush_id, pif.flush_ex, pif.flush_mem, pif.mdu_start, pif.trap_req,
                     pif.stall_cnt, pif.flush_cnt};
         checks++;
         if (mon_act !== mon_exp) begin
            errors++;
            $display("FAIL %s: got ctl=%b stall_cnt=%0d flush_cnt=%0d, expected ctl=%b stall_cnt=%0d flush_cnt=%0d",
                     mon_name, mon_act[20:8], mon_act[7:4], mon_act[3:0],
                     mon_exp[20:8], mon_exp[7:4], mon_exp[3:0]);
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: time limit reached, %0d expectations still pending", exp_q.size());
      $fatal(1);
   end

   initial begin
      apply(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, C_RST));

      step("rst_hold",     mk(5, 0, 2'b10, 1, 5, 0, 1, 5, C_RST), E_RST);
      step("idle",         mk(0, 0, 2'b00, 0, 0, 0, 0, 0, C_NONE), E_NONE);
      step("fwd_mem_rs1",  mk(5, 0, 2'b10, 1, 5, 0, 0, 0, C_NONE), 13'b1000_0000_000_0_0);
      step("fwd_wb_rs2",   mk(0, 9, 2'b01, 0, 0, 0, 1, 9, C_NONE), 13'b0001_0000_000_0_0);
      step("fwd_mem_prio", mk(3, 3, 2'b11, 1, 3, 0, 1, 3, C_NONE), 13'b1010_0000_000_0_0);
      step("fwd_both",     mk(6, 8, 2'b11, 1, 6, 0, 1, 8, C_NONE), 13'b1001_0000_000_0_0);
      step("x0_no_fwd",    mk(0, 0, 2'b11, 1, 0, 0, 1, 0, C_NONE), E_NONE);
      step("no_read",      mk(5, 5, 2'b00, 1, 5, 0, 1, 5, C_NONE), E_NONE);
      step("load_use",     mk(0, 7, 2'b01, 1, 7, 1, 0, 0, C_NONE), E_LU);
      step("load_use_wb",  mk(0, 7, 2'b01, 0, 0, 0, 1, 7, C_NONE), 13'b0001_0000_000_0_0);
      step("br_over_lu",   mk(4, 0, 2'b10, 1, 4, 1, 0, 0, C_BR), E_BR);
      step("after_br",     mk(0, 0, 2'b00, 0, 0, 0, 0, 0, C_NONE), E_NONE);

      step("mdu_start",    mk(0, 0, 2'b00, 0, 0, 0, 0, 0, C_MDU | C_DONE), E_MDU0);
      step("mdu_wait",     mk(0, 0, 2'b00, 0, 0, 0, 0, 0, C_MDU), E_MDUW);
      step("mdu_wait_lsu", mk(0, 0, 2'b00, 0, 0, 0, 0, 0, C_MDU | C_LSU), E_STALL);
      step("mdu_wait",     mk(0, 0, 2'b00, 0, 0, 0, 0, 0, C_MDU), E_MDUW);
      step("mdu_wait",     mk(0, 0, 2'b00, 0, 0, 0, 0, 0, C_MDU), E_MDUW);
      step("mdu_done",     mk(0, 0, 2'b00, 0, 0, 0, 0, 0, C_MDU | C_DONE), E_NONE);
      step("mdu_run",      mk(0, 0, 2'b00, 0, 0, 0, 0, 0, C_NONE), E_NONE);

      step("lsu_enter",    mk(0, 0, 2'b00, 0, 0, 0, 0, 0, C_LSU), E_STALL);
      step("lsu_hold",     mk(0, 0, 2'b00, 0, 0, 0, 0, 0, C_LSU), E_STALL);
      step("lsu_exit",     mk(0, 0, 2'b00, 0, 0, 0, 0, 0, C_NONE), E_NONE);
      for (int i = 0; i < 10; i++)
         step("lsu_sat",   mk(0, 0, 2'b00, 0, 0, 0, 0, 0, C_LSU), E_STALL);
      step("lsu_sat_exit", mk(0, 0, 2'b00, 0, 0, 0, 0, 0, C_NONE), E_NONE);
      for (int i = 0; i < 16; i++)
         step("br_sat",    mk(0, 0, 2'b00, 0, 0, 0, 0, 0, C_BR), E_BR);
      step("br_sat_exit",  mk(0, 0, 2'b00, 0, 0, 0, 0, 0, C_NONE), E_NONE);

      step("trap_enter",   mk(0, 7, 2'b01, 1, 7, 1, 0, 0, C_ILL | C_LSU), E_RST);
      step("trap_wait",    mk(0, 0, 2'b00, 0, 0, 0, 0, 0, C_NONE), E_TRAPW);
      step("trap_wait",    mk(0, 0, 2'b00, 0, 0, 0, 0, 0, C_NONE), E_TRAPW);
      step("trap_ack",     mk(0, 0, 2'b00, 0, 0, 0, 0, 0, C_ACK), E_TRAPA);
      step("trap_done",    mk(0, 0, 2'b00, 0, 0, 0, 0, 0, C_NONE), E_NONE);

      step("trap2_enter",  mk(0, 0, 2'b00, 0, 0, 0, 0, 0, C_ILL), E_RST);
      step("trap2_wait",   mk(0, 0, 2'b00, 0, 0, 0, 0, 0, C_NONE), E_TRAPW);
      step("trap2_rst",    mk(0, 0, 2'b00, 0, 0, 0, 0, 0, C_RST), E_RST);
      step("trap2_post",   mk(0, 0, 2'b00, 0, 0, 0, 0, 0, C_NONE), E_NONE);

      step("mdu2_start",   mk(0, 0, 2'b00, 0, 0, 0, 0, 0, C_MDU), E_MDU0);
      step("mdu2_rst",     mk(0, 0, 2'b00, 0, 0, 0, 0, 0, C_MDU | C_RST), E_RST);
      step("mdu2_post",    mk(0, 0, 2'b00, 0, 0, 0, 0, 0, C_NONE), E_NONE);
      step("final_fwd",    mk(2, 2, 2'b11, 0, 0, 0, 1, 2, C_NONE), 13'b0101_0000_000_0_0);

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
